irq_ctrl: RTL

- Memory-mapped interrupt controller on the 6502 peripheral bus, decoded in the system top (proposed window $FE40-$FE5F).
- Collects up to 8 external/peripheral interrupt sources (timer, UART, …) and drives the CPU IRQ input, which the system top currently ties low.
- Provides per-source pending latching, enable masking, edge/level selection, software trigger, and a priority-encoded vector register for the ISR.

---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// CPU peripheral-bus port of the interrupt controller: write data, register
// select, write strobe and registered read data.
interface irq_ctrl_if;
  logic [7:0] dbr;
  logic [7:0] dbw;
  logic [1:0] addr;
  logic       we;

  modport master (output dbw, output addr, output we, input dbr);
  modport slave  (input dbw, input addr, input we, output dbr);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: per-source pending latch, enable mask,
// edge/level select, software trigger and a priority-encoded vector register.
module irq_ctrl #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  EDGE_RST    = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] src,
  output logic             irq
);

  localparam int unsigned ARM_W = 3;
  localparam logic [ARM_W-1:0] ARM_N = ARM_W'(SYNC_STAGES + 1);

  localparam logic [1:0] A_PEND   = 2'd0;
  localparam logic [1:0] A_ENABLE = 2'd1;
  localparam logic [1:0] A_EDGE   = 2'd2;
  localparam logic [1:0] A_VECTOR = 2'd3;

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] s_d_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] en_q, en_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [7:0]       dbr_q, dbr_d;
  logic             irq_q, irq_d;

  logic             armed_c;
  logic [N_SRC-1:0] edge_det_c;
  logic [N_SRC-1:0] clr_c, set_c;
  logic [N_SRC-1:0] active_c;
  logic             any_c;
  logic [2:0]       idx_c;

  // Input synchronizer chain; s is the synchronized view of src.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = src;
    end else begin : g_sync
      logic [N_SRC-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= src;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edges are ignored until the synchronizer and s_d have filled after reset,
  // so a source already high at reset release never looks like a new edge.
  always_comb begin
    armed_c   = (arm_cnt_q == ARM_N);
    arm_cnt_d = armed_c ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
  end

  // Register writes, edge detection and the pending next-state.
  always_comb begin
    edge_det_c = s & ~s_d_q & {N_SRC{armed_c}};
    clr_c      = (bus.we && bus.addr == A_PEND)   ? bus.dbw[N_SRC-1:0] : '0;
    set_c      = (bus.we && bus.addr == A_VECTOR) ? bus.dbw[N_SRC-1:0] : '0;
    en_d       = (bus.we && bus.addr == A_ENABLE) ? bus.dbw[N_SRC-1:0] : en_q;
    edge_d     = (bus.we && bus.addr == A_EDGE)   ? bus.dbw[N_SRC-1:0] : edge_q;
    pend_d     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!edge_d[i]) begin
        pend_d[i] = s[i];
      end else if (!edge_q[i]) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = (pend_q[i] & ~clr_c[i]) | edge_det_c[i] | set_c[i];
      end
    end
  end

  // Lowest-numbered enabled pending source wins the vector.
  always_comb begin
    active_c = pend_q & en_q;
    any_c    = |active_c;
    idx_c    = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active_c[i]) idx_c = 3'(i);
    end
  end

  // Read mux and irq next-state; reads never have side effects.
  always_comb begin
    irq_d = any_c;
    dbr_d = 8'h00;
    case (bus.addr)
      A_PEND:   dbr_d = 8'(pend_q);
      A_ENABLE: dbr_d = 8'(en_q);
      A_EDGE:   dbr_d = 8'(edge_q);
      A_VECTOR: dbr_d = {any_c, 4'b0000, idx_c};
      default:  dbr_d = 8'h00;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d_q     <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      edge_q    <= EDGE_RST[N_SRC-1:0];
      arm_cnt_q <= '0;
      dbr_q     <= 8'h00;
      irq_q     <= 1'b0;
    end else begin
      s_d_q     <= s;
      pend_q    <= pend_d;
      en_q      <= en_d;
      edge_q    <= edge_d;
      arm_cnt_q <= arm_cnt_d;
      dbr_q     <= dbr_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.dbr = dbr_q;
  assign irq     = irq_q;

endmodule
